// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 target, MSB first, with one-entry TX holding buffer and RX valid pulse.
// Ports:
//   i_clk, i_rst            system clock (>= 8x SCLK), asynchronous active-high reset
//   i_sclk, i_cs_n, i_mosi  asynchronous SPI inputs from the controller
//   o_miso, o_miso_oe       target-out data and its output enable (high while selected)
//   i_tx_data, i_tx_valid, o_tx_ready   write port of the TX holding buffer
//   o_rx_data, o_rx_valid   last complete received word and its one-cycle update pulse
module spi_peripheral #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       sclk_q, cs_q;
    logic [1:0]       mosi_q;
    logic [WIDTH-1:0] buf_q, buf_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic             full_q, full_d, rx_valid_q, rx_valid_d, reload_q, reload_d, load;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sclk_rise, sclk_fall, cs_rise, cs_fall;

    // [0],[1] are the two synchronizer stages, [2] is the history bit for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], i_sclk};
            cs_q   <= {cs_q[1:0], i_cs_n};
            mosi_q <= {mosi_q[0], i_mosi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        full_d     = full_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cnt_d      = cnt_q;
        reload_d   = reload_q;
        load       = 1'b0;
        if (state_q == IDLE) begin
            if (cs_fall) begin
                state_d  = ACTIVE;
                load     = 1'b1;
                cnt_d    = '0;
                reload_d = 1'b0;
            end
        end else if (cs_rise) begin
            // deselect outranks any SCLK edge seen in the same cycle
            state_d  = IDLE;
            cnt_d    = '0;
            reload_d = 1'b0;
        end else if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_q[1]};
            if (cnt_q == CW'(WIDTH - 1)) begin
                rx_data_d  = rx_sh_d;
                rx_valid_d = 1'b1;
                cnt_d      = '0;
                reload_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (sclk_fall) begin
            if (reload_q) begin
                load     = 1'b1;
                reload_d = 1'b0;
            end else begin
                tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
            end
        end
        // an empty buffer at load time sends zeros (underrun)
        if (load) begin
            tx_sh_d = full_q ? buf_q : '0;
            full_d  = 1'b0;
        end
        if (i_tx_valid && !full_q) begin
            buf_d  = i_tx_data;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            full_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cnt_q      <= '0;
            reload_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
        end
    end

    assign o_miso_oe  = state_q == ACTIVE;
    assign o_miso     = o_miso_oe & tx_sh_q[WIDTH-1];
    assign o_tx_ready = ~full_q;
    assign o_rx_data  = rx_data_q;
    assign o_rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed bench for spi_peripheral acting as a mode-0 SPI controller.
// Ports: none (top-level bench).
module tb_spi_peripheral;
    localparam int H = 6;

    typedef struct {
        logic       wr;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_rx;
        logic [7:0] exp_mi;
    } vec_t;

    logic       clk = 1'b0, rst = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, oe, tx_ready, rx_valid;
    logic [7:0] rx_data;
    logic [7:0] rx_q[$];
    int         n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    spi_peripheral #(.WIDTH(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_cs_n(cs_n), .i_mosi(mosi),
        .o_miso(miso), .o_miso_oe(oe),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_rx_data(rx_data), .o_rx_valid(rx_valid)
    );

    always @(negedge clk) if (rx_valid) rx_q.push_back(rx_data);

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic write_tx(input logic [7:0] d);
        int t = 0;
        while (!tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("tx_ready_wait", {15'b0, tx_ready}, 16'h1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic shift(input int n, input logic [15:0] mo, output logic [15:0] mi);
        mi = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = mo[i];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            mi   = {mi[14:0], miso};
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic xfer(input int n, input logic [15:0] mo, output logic [15:0] mi);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        shift(n, mo, mi);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_word(input string nm, input logic [7:0] exp_rx, input logic [7:0] exp_mi,
                              input logic [15:0] mi);
        chk({nm, "_rx_cnt"}, 16'(rx_q.size()), 16'd1);
        chk({nm, "_rx_word"}, rx_q.size() > 0 ? {8'h00, rx_q[0]} : 16'hxxxx, {8'h00, exp_rx});
        chk({nm, "_rx_data"}, {8'h00, rx_data}, {8'h00, exp_rx});
        chk({nm, "_miso"}, mi, {8'h00, exp_mi});
        chk({nm, "_oe_off"}, {15'b0, oe}, 16'h0);
    endtask

    vec_t        v[6];
    logic [15:0] mi;

    initial begin
        v[0] = '{1'b1, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
        v[1] = '{1'b0, 8'h00, 8'h5A, 8'h5A, 8'h00};
        v[2] = '{1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF};
        v[3] = '{1'b1, 8'h80, 8'h01, 8'h01, 8'h80};
        v[4] = '{1'b1, 8'h01, 8'h80, 8'h80, 8'h01};
        v[5] = '{1'b1, 8'hC3, 8'h96, 8'h96, 8'hC3};

        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            sclk = ~sclk;
        end
        chk("rst_miso", {15'b0, miso}, 16'h0);
        chk("rst_oe", {15'b0, oe}, 16'h0);
        chk("rst_rx_data", {8'h00, rx_data}, 16'h0);
        chk("rst_rx_valid", {15'b0, rx_valid}, 16'h0);
        chk("rst_tx_ready", {15'b0, tx_ready}, 16'h1);
        sclk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_oe", {15'b0, oe}, 16'h0);
        chk("post_rst_ready", {15'b0, tx_ready}, 16'h1);

        for (int k = 0; k < 6; k++) begin
            rx_q.delete();
            if (v[k].wr) write_tx(v[k].tx);
            xfer(8, {8'h00, v[k].mo}, mi);
            check_word($sformatf("vec%0d", k), v[k].exp_rx, v[k].exp_mi, mi);
            chk($sformatf("vec%0d_ready", k), {15'b0, tx_ready}, 16'h1);
        end

        rx_q.delete();
        write_tx(8'h11);
        cs_n = 1'b0;
        write_tx(8'h22);
        repeat (4) @(negedge clk);
        shift(16, 16'hF00F, mi);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("b2b_rx_cnt", 16'(rx_q.size()), 16'd2);
        chk("b2b_rx0", rx_q.size() > 0 ? {8'h00, rx_q[0]} : 16'hxxxx, 16'h00F0);
        chk("b2b_rx1", rx_q.size() > 1 ? {8'h00, rx_q[1]} : 16'hxxxx, 16'h000F);
        chk("b2b_miso", mi, 16'h1122);

        rx_q.delete();
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        shift(3, 16'h0005, mi);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("partial_rx_cnt", 16'(rx_q.size()), 16'd0);
        chk("partial_oe", {15'b0, oe}, 16'h0);
        chk("partial_miso", {15'b0, miso}, 16'h0);
        write_tx(8'h69);
        xfer(8, 16'h00C3, mi);
        check_word("after_partial", 8'hC3, 8'h69, mi);

        rx_q.delete();
        write_tx(8'h77);
        cs_n = 1'b0;
        repeat (8) @(negedge clk);
        shift(4, 16'h000A, mi);
        write_tx(8'h55);
        rst = 1'b1;
        #1;
        chk("midrst_oe", {15'b0, oe}, 16'h0);
        chk("midrst_miso", {15'b0, miso}, 16'h0);
        chk("midrst_rx_data", {8'h00, rx_data}, 16'h0);
        chk("midrst_tx_ready", {15'b0, tx_ready}, 16'h1);
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_rx_cnt", 16'(rx_q.size()), 16'd0);
        xfer(8, 16'h003E, mi);
        check_word("after_rst_empty", 8'h3E, 8'h00, mi);
        rx_q.delete();
        write_tx(8'h96);
        xfer(8, 16'h0081, mi);
        check_word("after_rst_full", 8'h81, 8'h96, mi);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
